tpu_layer_sequencer: RTL

// - Parametrised N x N successor to the host-driven tpu top-level control.
// - Takes one layer command per valid/ready handshake and generates the full strobe sequence itself:
//   - unified_buffer weight read -> systolic switch -> input/bias reads -> VPU writeback address.
// - Sits between the host command port and the unified_buffer / systolic / vpu control pins.
// - Counts VPU results to detect layer completion; reports done plus a status code.

---
 rtl/tpu_layer_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tpu_layer_sequencer.sv
// Layer-level sequencer for an N x N systolic TPU: accepts one layer command and
// issues the weight-load, switch, input/bias read and writeback strobes, then waits for VPU results.
module tpu_layer_sequencer #(
  parameter int N          = 2,
  parameter int ADDR_W     = 6,
  parameter int ROW_W      = 6,
  parameter int W_LOAD_LAT = 4,
  parameter int TIMEOUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [ADDR_W-1:0] cmd_input_addr_in,
  input  logic [ADDR_W-1:0] cmd_weight_addr_in,
  input  logic [ADDR_W-1:0] cmd_bias_addr_in,
  input  logic [ADDR_W-1:0] cmd_out_addr_in,
  input  logic [ROW_W-1:0]  cmd_rows_in,
  input  logic [3:0]        cmd_pathway_in,
  input  logic              cmd_input_transpose_in,
  input  logic              cmd_weight_transpose_in,
  input  logic              abort_in,
  input  logic              vpu_valid_in_1,
  output logic              ub_rd_weight_start_out,
  output logic [ADDR_W-1:0] ub_rd_weight_addr_out,
  output logic [ADDR_W-1:0] ub_rd_weight_loc_out,
  output logic              ub_rd_weight_transpose_out,
  output logic              ub_rd_input_start_out,
  output logic [ADDR_W-1:0] ub_rd_input_addr_out,
  output logic [ADDR_W-1:0] ub_rd_input_loc_out,
  output logic              ub_rd_input_transpose_out,
  output logic              ub_rd_bias_start_out,
  output logic [ADDR_W-1:0] ub_rd_bias_addr_out,
  output logic [ADDR_W-1:0] ub_rd_bias_loc_out,
  output logic              sys_switch_out,
  output logic [3:0]        vpu_data_pathway_out,
  output logic [ADDR_W-1:0] ub_wr_addr_out,
  output logic              ub_wr_addr_valid_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [1:0]        status_out
);

  localparam int WAIT_W = $clog2(W_LOAD_LAT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(W_LOAD_LAT - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ZERO    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [WAIT_W-1:0]     wait_cnt, wait_next;
  logic [ROW_W-1:0]      res_cnt, res_next, res_inc;
  logic [TIMEOUT_W-1:0]  to_cnt, to_next;
  logic [1:0]            status, status_next;
  logic                  accept, weight_start, switch_pulse, done_pulse;

  logic [ADDR_W-1:0]     input_addr_q, weight_addr_q, bias_addr_q, out_addr_q, weight_loc_q;
  logic [ROW_W-1:0]      rows_q;
  logic [3:0]            pathway_q;
  logic                  input_tr_q, weight_tr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      res_cnt       <= '0;
      to_cnt        <= '0;
      status        <= ST_OK;
      input_addr_q  <= '0;
      weight_addr_q <= '0;
      bias_addr_q   <= '0;
      out_addr_q    <= '0;
      weight_loc_q  <= '0;
      rows_q        <= '0;
      pathway_q     <= '0;
      input_tr_q    <= 1'b0;
      weight_tr_q   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      res_cnt  <= res_next;
      to_cnt   <= to_next;
      status   <= status_next;
      if (accept) begin
        input_addr_q  <= cmd_input_addr_in;
        weight_addr_q <= cmd_weight_addr_in;
        bias_addr_q   <= cmd_bias_addr_in;
        out_addr_q    <= cmd_out_addr_in;
        weight_loc_q  <= ADDR_W'(N);
        rows_q        <= cmd_rows_in;
        pathway_q     <= cmd_pathway_in;
        input_tr_q    <= cmd_input_transpose_in;
        weight_tr_q   <= cmd_weight_transpose_in;
      end
    end
  end

  // Abort is tested before completion and timeout so it wins any tie.
  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    res_next     = res_cnt;
    to_next      = to_cnt;
    status_next  = status;
    accept       = 1'b0;
    weight_start = 1'b0;
    switch_pulse = 1'b0;
    done_pulse   = 1'b0;
    res_inc      = res_cnt + ROW_W'(vpu_valid_in_1);
    unique case (state)
      IDLE: begin
        if (cmd_valid_in) begin
          accept    = 1'b1;
          wait_next = '0;
          res_next  = '0;
          to_next   = '0;
          if (cmd_rows_in == '0) begin
            state_next  = DONE;
            status_next = ST_ZERO;
          end else begin
            state_next = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        weight_start = (wait_cnt == '0);
        if (abort_in) begin
          state_next  = DONE;
          status_next = ST_ABORT;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = SWITCH;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      SWITCH: begin
        switch_pulse = 1'b1;
        to_next      = '0;
        res_next     = res_inc;
        if (abort_in) begin
          state_next  = DONE;
          status_next = ST_ABORT;
        end else if (res_inc == rows_q) begin
          state_next  = DONE;
          status_next = ST_OK;
        end else begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        res_next = res_inc;
        if (abort_in) begin
          state_next  = DONE;
          status_next = ST_ABORT;
        end else if (vpu_valid_in_1) begin
          to_next = '0;
          if (res_inc == rows_q) begin
            state_next  = DONE;
            status_next = ST_OK;
          end
        end else if (to_cnt == TO_LAST) begin
          state_next  = DONE;
          status_next = ST_TIMEOUT;
        end else begin
          to_next = to_cnt + 1'b1;
        end
      end
      DONE: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready_out              = (state == IDLE);
  assign busy_out                   = (state != IDLE);
  assign done_out                   = done_pulse;
  assign status_out                 = status;
  assign ub_rd_weight_start_out     = weight_start;
  assign ub_rd_weight_addr_out      = weight_addr_q;
  assign ub_rd_weight_loc_out       = weight_loc_q;
  assign ub_rd_weight_transpose_out = weight_tr_q;
  assign ub_rd_input_start_out      = switch_pulse;
  assign ub_rd_input_addr_out       = input_addr_q;
  assign ub_rd_input_loc_out        = ADDR_W'(rows_q);
  assign ub_rd_input_transpose_out  = input_tr_q;
  assign ub_rd_bias_start_out       = switch_pulse;
  assign ub_rd_bias_addr_out        = bias_addr_q;
  assign ub_rd_bias_loc_out         = ADDR_W'(rows_q);
  assign sys_switch_out             = switch_pulse;
  assign vpu_data_pathway_out       = pathway_q;
  assign ub_wr_addr_out             = out_addr_q;
  assign ub_wr_addr_valid_out       = switch_pulse;

endmodule
